lfsr_color_gen: RTL and testbench

LFSR_COLOR_GEN -- requirements
Module: lfsr_color_gen

---
 rtl/lfsr_color_gen.sv | 160 ++++++++++++++++
 tb/tb_lfsr_color_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_color_gen.sv
// LFSR colour generator: prescaled or on-demand LFSR steps, colour taken from odd state bits.
// Latency: 1 cycle from accepted request to state/color, color_vld marks that cycle.
// No backpressure; optional LFSR_NO_REPEAT_EN re-steps until the colour changes (busy high).
module lfsr_color_gen #(
    parameter int               WIDTH = 8,
    parameter int               CW    = 3,
    parameter int               DIV   = 50_000_000,
    parameter logic [WIDTH-1:0] SEED  = 'h07
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             change,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [CW-1:0]    color,
    output logic [WIDTH-1:0] state,
    output logic             color_vld,
    output logic             busy
);

    if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
        $error("lfsr_color_gen: WIDTH must be 8, 16 or 32");
    end
    if (2 * CW - 1 >= WIDTH) begin : g_bad_cw
        $error("lfsr_color_gen: 2*CW-1 must be below WIDTH");
    end
    if (DIV < 1) begin : g_bad_div
        $error("lfsr_color_gen: DIV must be at least 1");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_color_gen: SEED must be nonzero");
    end

    // Maximal-length tap positions for each legal width.
    localparam int T0 = (WIDTH == 8) ? 7 : (WIDTH == 16) ? 15 : 31;
    localparam int T1 = (WIDTH == 8) ? 5 : (WIDTH == 16) ? 14 : 21;
    localparam int T2 = (WIDTH == 8) ? 4 : (WIDTH == 16) ? 12 : 1;
    localparam int T3 = (WIDTH == 8) ? 3 : (WIDTH == 16) ? 3  : 0;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], s[T0] ^ s[T1] ^ s[T2] ^ s[T3]};
    endfunction

    function automatic logic [CW-1:0] col_of(input logic [WIDTH-1:0] s);
        logic [CW-1:0] c;
        for (int i = 0; i < CW; i++) begin
            c[i] = s[2*i+1];
        end
        return c;
    endfunction

    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic             vld_q, vld_d;
    logic             tick;
    logic [WIDTH-1:0] seed_fix;
    logic [WIDTH-1:0] adv_s;

    assign tick     = (pre_q == PW'(DIV - 1));
    assign seed_fix = (seed_in == '0) ? SEED : seed_in;
    assign adv_s    = adv(state_q);

    always_comb begin
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

`ifdef LFSR_NO_REPEAT_EN
    typedef enum logic {IDLE = 1'b0, RESTEP = 1'b1} fsm_t;
    localparam int RCW = $clog2(2 * WIDTH);

    fsm_t           fsm_q, fsm_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q  <= IDLE;
            rcnt_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            rcnt_q <= rcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vld_d   = 1'b0;
        fsm_d   = fsm_q;
        rcnt_d  = rcnt_q;
        case (fsm_q)
            IDLE: begin
                if (load) begin
                    state_d = seed_fix;
                    vld_d   = 1'b1;
                end else if (step || (tick && change)) begin
                    state_d = adv_s;
                    // Same colour: hide this step and keep stepping until it changes.
                    if (col_of(adv_s) == col_of(state_q)) begin
                        fsm_d  = RESTEP;
                        rcnt_d = '0;
                    end else begin
                        vld_d = 1'b1;
                    end
                end
            end
            RESTEP: begin
                if (load) begin
                    state_d = seed_fix;
                    vld_d   = 1'b1;
                    fsm_d   = IDLE;
                end else begin
                    state_d = adv_s;
                    if (col_of(adv_s) != col_of(state_q) ||
                        rcnt_q == RCW'(2 * WIDTH - 1)) begin
                        vld_d = 1'b1;
                        fsm_d = IDLE;
                    end else begin
                        rcnt_d = rcnt_q + RCW'(1);
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign busy = (fsm_q == RESTEP);
`else
    always_comb begin
        state_d = state_q;
        vld_d   = 1'b0;
        if (load) begin
            state_d = seed_fix;
            vld_d   = 1'b1;
        end else if (step || (tick && change)) begin
            state_d = adv_s;
            vld_d   = 1'b1;
        end
    end

    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q   <= '0;
            state_q <= SEED;
            vld_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            state_q <= state_d;
            vld_q   <= vld_d;
        end
    end

    assign state     = state_q;
    assign color     = col_of(state_q);
    assign color_vld = vld_q;

endmodule

// File: tb/tb_lfsr_color_gen.sv
// Bench for lfsr_color_gen (WIDTH=8, CW=3, DIV=4): directed steps then random stimulus vs. a reference model.
module tb_lfsr_color_gen;
    localparam int W   = 8;
    localparam int CW  = 3;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       change = 1'b0;
    logic       step = 1'b0;
    logic       load = 1'b0;
    logic [7:0] seed_in = 8'h00;
    logic [2:0] color;
    logic [7:0] state;
    logic       color_vld;
    logic       busy;

    always #5 clk = ~clk;

    lfsr_color_gen #(.WIDTH(W), .CW(CW), .DIV(DIV), .SEED(8'h07)) dut (
        .clk(clk), .rst(rst), .change(change), .step(step), .load(load),
        .seed_in(seed_in), .color(color), .state(state),
        .color_vld(color_vld), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain integer arithmetic, re-step sequence precomputed into a queue.
    int m_state;
    int m_vld;
    int m_cyc;
    int m_q[$];

    function automatic int m_adv(int s);
        int par = 0;
        for (int b = 0; b < 8; b++)
            if (b == 7 || b == 5 || b == 4 || b == 3) par += (s >> b) % 2;
        return ((s * 2) % 256) + (par % 2);
    endfunction

    function automatic int m_col(int s);
        int c = 0;
        for (int i = 0; i < CW; i++) c += ((s >> (2 * i + 1)) % 2) << i;
        return c;
    endfunction

    function automatic int m_seed(int v);
        return (v == 0) ? 7 : v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_state = 7;
        m_vld   = 0;
        m_cyc   = 0;
        m_q.delete();
    endtask

    task automatic chk_all(string tag);
        chk({tag, "_state"}, 32'(state), 32'(m_state));
        chk({tag, "_color"}, 32'(color), 32'(m_col(m_state)));
        chk({tag, "_vld"},   32'(color_vld), 32'(m_vld));
        chk({tag, "_busy"},  32'(busy), (m_q.size() > 0) ? 32'd1 : 32'd0);
    endtask

    // One clock edge with current inputs held, model update, then full output check.
    task automatic cycle(string tag);
        bit tick;
        int nxt;
        int s;
        @(posedge clk);
        #1;
        tick = ((m_cyc + 1) % DIV == 0);
        m_cyc++;
        m_vld = 0;
        if (m_q.size() > 0) begin
            if (load) begin
                m_q.delete();
                m_state = m_seed(int'(seed_in));
                m_vld   = 1;
            end else begin
                m_state = m_q.pop_front();
                m_vld   = (m_q.size() == 0) ? 1 : 0;
            end
        end else if (load) begin
            m_state = m_seed(int'(seed_in));
            m_vld   = 1;
        end else if (step || (tick && change)) begin
            nxt = m_adv(m_state);
`ifdef LFSR_NO_REPEAT_EN
            if (m_col(nxt) == m_col(m_state)) begin
                s = nxt;
                for (int i = 0; i < 2 * W; i++) begin
                    s = m_adv(s);
                    m_q.push_back(s);
                    if (m_col(s) != m_col(nxt)) break;
                end
            end else begin
                m_vld = 1;
            end
`else
            s = nxt;
            m_vld = 1;
`endif
            m_state = nxt;
        end
        chk_all(tag);
    endtask

    task automatic do_reset(string tag);
        rst = 1'b0;
        #1;
        m_reset();
        chk_all(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int pulses[$];
        int cnt;

        // Reset state
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'h07);
        chk("rst_color", 32'(color), 32'h1);
        chk("rst_vld", 32'(color_vld), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        cycle("idle0");
        cycle("idle1");

        // Two manual steps from the seed
        step = 1'b1;
        cycle("step1");
        step = 1'b0;
        chk("step1_lit", 32'(state), 32'h0E);
        chk("step1_col", 32'(color), 32'h3);
        chk("step1_v", 32'(color_vld), 32'h1);
        cycle("step1_gap");
        chk("step1_gap_v", 32'(color_vld), 32'h0);
        step = 1'b1;
        cycle("step2");
        step = 1'b0;
        chk("step2_lit", 32'(state), 32'h1D);
        chk("step2_col", 32'(color), 32'h2);
        chk("step2_v", 32'(color_vld), 32'h1);

        // Tick-driven advance with change held high, then low
        change = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cycle("tick_on");
            if (color_vld) pulses.push_back(c);
        end
        change = 1'b0;
        chk("tick_cnt", 32'(pulses.size()), 32'd5);
        for (int i = 1; i < pulses.size(); i++)
            chk("tick_gap", 32'(pulses[i] - pulses[i-1]), 32'd4);
        chk("tick_end", 32'(state), 32'hAA);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            cycle("tick_off");
            if (color_vld) cnt++;
        end
        chk("tick_off_cnt", 32'(cnt), 32'd0);
        chk("tick_off_hold", 32'(state), 32'hAA);

        // Zero load substitutes seed; load beats step
        load = 1'b1;
        seed_in = 8'h00;
        cycle("load0");
        chk("load0_lit", 32'(state), 32'h07);
        chk("load0_v", 32'(color_vld), 32'h1);
        step = 1'b1;
        seed_in = 8'h03;
        cycle("load_step");
        load = 1'b0;
        step = 1'b0;
        chk("load_step_lit", 32'(state), 32'h03);

        // Step whose colour repeats
        step = 1'b1;
        cycle("rep1");
        step = 1'b0;
`ifdef LFSR_NO_REPEAT_EN
        chk("rep1_lit", 32'(state), 32'h06);
        chk("rep1_busy", 32'(busy), 32'h1);
        chk("rep1_v", 32'(color_vld), 32'h0);
        cycle("rep2");
        chk("rep2_lit", 32'(state), 32'h0C);
        chk("rep2_col", 32'(color), 32'h2);
        chk("rep2_v", 32'(color_vld), 32'h1);
        chk("rep2_busy", 32'(busy), 32'h0);
`else
        chk("rep1_lit", 32'(state), 32'h06);
        chk("rep1_col", 32'(color), 32'h1);
        chk("rep1_v", 32'(color_vld), 32'h1);
`endif
        cycle("rep_after");
        chk("rep_after_v", 32'(color_vld), 32'h0);

        // Reset during a (possible) re-step sequence
        load = 1'b1;
        seed_in = 8'h03;
        cycle("mid_load");
        load = 1'b0;
        step = 1'b1;
        cycle("mid_step");
        step = 1'b0;
        do_reset("mid_rst");
        chk("mid_rst_lit", 32'(state), 32'h07);
        for (int c = 0; c < 6; c++) begin
            cycle("post_rst");
            chk("post_rst_v", 32'(color_vld), 32'h0);
        end

        // Random requests against the model
        for (int c = 0; c < 400; c++) begin
            load    = ($urandom_range(15) == 0);
            step    = ($urandom_range(3) == 0);
            change  = ($urandom_range(1) == 1);
            seed_in = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(255));
            cycle("rand");
        end
        load = 1'b0;
        step = 1'b0;
        change = 1'b0;
        for (int c = 0; c < 2 * W + 2; c++) cycle("drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
